// File: rtl/div_bus_pkg.sv
// div_bus_pkg
// Shared definitions for div_bus_master: FSM state encoding, response
// status codes and the default fin timeout.
package div_bus_pkg;

  // state    | meaning
  // ---------+---------------------------------------------------------
  // IDLE     | ready for a host request
  // START    | begin_div strobe, in_bus = 0
  // SEND_HI  | in_bus = dividend[15:8]
  // SEND_LO  | in_bus = dividend[7:0]
  // SEND_DIV | in_bus = divisor
  // WAIT_FIN | counting cycles until fin (quotient) or timeout
  // GET_REM  | capture remainder from out_bus
  // RESP     | response held until resp_ready
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_SEND_HI  = 3'd2,
    S_SEND_LO  = 3'd3,
    S_SEND_DIV = 3'd4,
    S_WAIT_FIN = 3'd5,
    S_GET_REM  = 3'd6,
    S_RESP     = 3'd7
  } state_t;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_DIV0 = 2'b01;
  localparam logic [1:0] ST_OVF  = 2'b10;
  localparam logic [1:0] ST_TMO  = 2'b11;

  localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/div_bus_master.sv
// div_bus_master
// Host-side bus master for an external byte-serial divider. A request
// (16-bit dividend, 8-bit divisor) is screened for divide-by-zero and
// quotient overflow, then sent as a start strobe followed by three bytes.
// The divider answers with fin + quotient, then the remainder on the next
// cycle. The result is returned through a valid/ready response port.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake; dividend, divisor sampled on accept
//   begin_div, in_bus     start strobe and byte bus to the divider
//   fin, out_bus          done strobe and result bus from the divider
//   resp_valid/resp_ready response handshake
//   quotient, remainder   result bytes
//   status                00 ok, 01 div-by-zero, 10 overflow, 11 timeout
module div_bus_master
  import div_bus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        begin_div,
  output logic [7:0]  in_bus,
  input  logic        fin,
  input  logic [7:0]  out_bus,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic [1:0]  status
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_dividend;
  logic [7:0]    r_divisor;
  logic [7:0]    r_quot;
  logic [7:0]    r_rem;
  logic [1:0]    r_status;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_tmo;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_tmo    = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          // Screened requests skip the divider entirely.
          if (divisor == 8'd0 || dividend[15:8] >= divisor) w_next = S_RESP;
          else                                              w_next = S_START;
        end
      end
      S_START:    w_next = S_SEND_HI;
      S_SEND_HI:  w_next = S_SEND_LO;
      S_SEND_LO:  w_next = S_SEND_DIV;
      S_SEND_DIV: w_next = S_WAIT_FIN;
      S_WAIT_FIN: begin
        // fin wins over timeout on the last counted cycle.
        if (fin)        w_next = S_GET_REM;
        else if (w_tmo) w_next = S_RESP;
      end
      S_GET_REM:  w_next = S_RESP;
      S_RESP:     if (resp_ready) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_status   <= ST_OK;
      r_cnt      <= '0;
    end else begin
      r_cnt <= (r_state == S_WAIT_FIN) ? r_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_dividend <= dividend;
        r_divisor  <= divisor;
        r_quot     <= '0;
        r_rem      <= '0;
        if (divisor == 8'd0)               r_status <= ST_DIV0;
        else if (dividend[15:8] >= divisor) r_status <= ST_OVF;
        else                               r_status <= ST_OK;
      end
      if (r_state == S_WAIT_FIN) begin
        if (fin)        r_quot   <= out_bus;
        else if (w_tmo) r_status <= ST_TMO;
      end
      if (r_state == S_GET_REM) r_rem <= out_bus;
    end
  end

  always_comb begin
    in_bus = 8'd0;
    case (r_state)
      S_SEND_HI:  in_bus = r_dividend[15:8];
      S_SEND_LO:  in_bus = r_dividend[7:0];
      S_SEND_DIV: in_bus = r_divisor;
      default:    in_bus = 8'd0;
    endcase
  end

  assign req_ready  = (r_state == S_IDLE);
  assign begin_div  = (r_state == S_START);
  assign resp_valid = (r_state == S_RESP);
  assign quotient   = r_quot;
  assign remainder  = r_rem;
  assign status     = r_status;

endmodule

// File: doc/div_bus_master.md
DIV_BUS_MASTER -- requirements
Module: div_bus_master

Interface
REQ-001 Parameter: TIMEOUT, default 64, max cycles waited for fin after the divisor byte is sent.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  host request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 dividend  input  16  unsigned dividend, sampled on acceptance.
REQ-007 divisor  input  8  unsigned divisor, sampled on acceptance.
REQ-008 begin_div  output  1  start strobe to the divider.
REQ-009 in_bus  output  8  byte bus to the divider.
REQ-010 fin  input  1  divider done strobe.
REQ-011 out_bus  input  8  result bus from the divider.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  host accepts the response.
REQ-014 quotient  output  8  result quotient.
REQ-015 remainder  output  8  result remainder.
REQ-016 status  output  2  00 ok, 01 divide-by-zero, 10 overflow, 11 timeout.

Function
REQ-017 States SHALL be IDLE, START, SEND_HI, SEND_LO, SEND_DIV, WAIT_FIN, GET_REM, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; acceptance is req_valid && req_ready at a rising edge.
REQ-019 On acceptance with divisor == 0, the block SHALL go to RESP with status 01, quotient 0, remainder 0, and never assert begin_div.
REQ-020 On acceptance with dividend[15:8] >= divisor (nonzero), the block SHALL go to RESP with status 10, quotient 0, remainder 0, and never assert begin_div.
REQ-021 Otherwise the block SHALL go to START.
REQ-022 START: begin_div=1, in_bus=0, for exactly one cycle.
REQ-023 SEND_HI, SEND_LO, SEND_DIV SHALL each last one cycle, driving in_bus = dividend[15:8], dividend[7:0], divisor respectively, with begin_div=0.
REQ-024 In all states other than SEND_HI, SEND_LO and SEND_DIV, in_bus SHALL be 0; begin_div is 1 only in START.
REQ-025 WAIT_FIN SHALL run a cycle counter from 0; fin=1 SHALL capture out_bus as quotient and move to GET_REM.
REQ-026 GET_REM SHALL capture out_bus as remainder unconditionally and move to RESP with status 00.
REQ-027 If the counter reaches TIMEOUT-1 with fin=0, the block SHALL go to RESP with status 11, quotient 0, remainder 0.
REQ-028 fin SHALL be ignored in every state other than WAIT_FIN.
REQ-029 RESP: resp_valid=1; quotient, remainder and status SHALL stay stable until resp_valid && resp_ready, then the block SHALL return to IDLE.
REQ-030 Latency: begin_div SHALL assert in the cycle after acceptance; resp_valid SHALL assert two cycles after the cycle in which fin is sampled high.
REQ-031 All outputs SHALL be registered or decoded from registered state only; there are no combinational paths from input to output.

Reset
REQ-032 On rst=1, the block SHALL enter IDLE immediately, regardless of clk.
REQ-033 Reset values SHALL be: req_ready=1, begin_div=0, in_bus=0, resp_valid=0, quotient=0, remainder=0, status=00, counter=0.
REQ-034 Reset mid-transaction SHALL drop the transaction without producing a response.

Structure
REQ-035 Package div_bus_pkg SHALL hold the state enum, the status code constants and the TIMEOUT default.
REQ-036 The block SHALL be a single module with no sub-module.

Verification
REQ-037 dividend 0x1FA9, divisor 0x4F; divider returns fin with out_bus 0x66, then 0x2F -> in_bus sequence 00,1F,A9,4F with begin_div on the first byte; response q=0x66, r=0x2F, status 00.
REQ-038 divisor 0x00 -> no begin_div; resp_valid the cycle after acceptance; status 01, q=0, r=0.
REQ-039 dividend 0x5000, divisor 0x4F -> no begin_div; status 10.
REQ-040 fin never asserted, TIMEOUT=64 -> status 11 after 64 WAIT_FIN cycles; req_ready returns to 1 after resp_ready.
REQ-041 rst pulsed during SEND_LO -> begin_div=0, in_bus=0 immediately; no resp_valid; next request completes normally.
REQ-042 resp_ready held 0 for 5 cycles -> outputs stable; req_ready=0 throughout; a spurious fin in RESP is ignored.
